// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and
// instruction memory. The fetch stage is the master: it owns req/addr and
// memory answers with ack/rdata (ack may be combinational on req).
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the single-outstanding
// req/ack handshake to instruction memory, drives the IF/ID register and
// parks a returning word in a one-entry skid register while decode stalls.
// Redirects that land while a request is in flight drain that request first.
// Optional build macro: FETCH_PERF_CNT_EN adds delivered/squashed counters;
// without it the perf outputs are tied to zero and no counter flops exist.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cpu_en,
  input  logic               Stall,
  input  logic               branchEnable,
  input  logic [31:0]        branchAddr,
  fetch_stage_if.master      imem,
  output logic [31:0]        if_id_instruction,
  output logic [31:0]        if_id_pc_4,
  output logic               if_id_valid,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_squash_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic        advance_s;
  logic        redirect_s;
  logic [31:0] target_s;
  logic [31:0] pc_plus4_s;

  assign advance_s  = ~Stall & cpu_en;
  assign redirect_s = branchEnable & advance_s;
  assign target_s   = branchAddr & 32'hFFFF_FFFC;
  assign pc_plus4_s = pc_q + 32'd4;

  // Request is raised in REQ and DRAIN; in DRAIN the PC still holds the
  // address of the in-flight request, so the address stays stable.
  assign imem.imem_req  = (state_q == S_REQ) || (state_q == S_DRAIN);
  assign imem.imem_addr = pc_q;

  assign if_id_instruction = ifid_instr_q;
  assign if_id_pc_4        = ifid_pc4_q;
  assign if_id_valid       = ifid_valid_q;

  // Next-state, PC, skid and IF/ID update for each handshake state.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_d       = pend_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    // Decode advancing with nothing new to take sees a bubble; otherwise hold.
    if (advance_s) begin
      ifid_instr_d = 32'h0000_0000;
      ifid_pc4_d   = 32'h0000_0000;
      ifid_valid_d = 1'b0;
    end else begin
      ifid_instr_d = ifid_instr_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_valid_d = ifid_valid_q;
    end

    case (state_q)
      S_IDLE: begin
        if (cpu_en) begin
          state_d = S_REQ;
          pc_d    = redirect_s ? target_s : pc_q;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (imem.imem_ack) begin
          if (redirect_s) begin
            pc_d = target_s;
          end else if (advance_s) begin
            ifid_instr_d = imem.imem_rdata;
            ifid_pc4_d   = pc_plus4_s;
            ifid_valid_d = 1'b1;
            pc_d         = pc_plus4_s;
          end else begin
            skid_instr_d = imem.imem_rdata;
            skid_pc4_d   = pc_plus4_s;
            pc_d         = pc_plus4_s;
            state_d      = S_HOLD;
          end
        end else if (redirect_s) begin
          pend_d  = target_s;
          state_d = S_DRAIN;
        end else begin
          state_d = S_REQ;
        end
      end
      S_HOLD: begin
        if (redirect_s) begin
          pc_d    = target_s;
          state_d = S_REQ;
        end else if (advance_s) begin
          ifid_instr_d = skid_instr_q;
          ifid_pc4_d   = skid_pc4_q;
          ifid_valid_d = 1'b1;
          state_d      = S_REQ;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_DRAIN: begin
        if (imem.imem_ack) begin
          pc_d    = redirect_s ? target_s : pend_q;
          state_d = S_REQ;
        end else if (redirect_s) begin
          pend_d = target_s;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, PC, pending target, skid and IF/ID registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      pend_q       <= 32'h0000_0000;
      skid_instr_q <= 32'h0000_0000;
      skid_pc4_q   <= 32'h0000_0000;
      ifid_instr_q <= 32'h0000_0000;
      ifid_pc4_q   <= 32'h0000_0000;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_q       <= pend_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] squash_cnt_q;
  logic        fetch_inc_s;
  logic        squash_inc_s;

  // A valid IF/ID load comes from a fresh ack or from the skid.
  assign fetch_inc_s  = advance_s & ~redirect_s &
                        (((state_q == S_REQ) & imem.imem_ack) | (state_q == S_HOLD));
  // Discarded ack words plus dropped skid words.
  assign squash_inc_s = (redirect_s & (((state_q == S_REQ) & imem.imem_ack) |
                                       (state_q == S_HOLD))) |
                        ((state_q == S_DRAIN) & imem.imem_ack);

  // Free-running wrap-around performance counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_cnt_q  <= 32'h0000_0000;
      squash_cnt_q <= 32'h0000_0000;
    end else begin
      fetch_cnt_q  <= fetch_cnt_q + {31'h0, fetch_inc_s};
      squash_cnt_q <= squash_cnt_q + {31'h0, squash_inc_s};
    end
  end

  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_squash_cnt = squash_cnt_q;
`else
  assign perf_fetch_cnt  = 32'h0000_0000;
  assign perf_squash_cnt = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a transaction-level model of the
// fetch behaviour plus directed vectors with hand-computed literals.
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_en = 1'b0;
  logic        Stall = 1'b0;
  logic        branchEnable = 1'b0;
  logic [31:0] branchAddr = 32'h0;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc_4;
  logic        if_id_valid;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_squash_cnt;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clock             (clock),
    .reset             (reset),
    .cpu_en            (cpu_en),
    .Stall             (Stall),
    .branchEnable      (branchEnable),
    .branchAddr        (branchAddr),
    .imem              (bus),
    .if_id_instruction (if_id_instruction),
    .if_id_pc_4        (if_id_pc_4),
    .if_id_valid       (if_id_valid),
    .perf_fetch_cnt    (perf_fetch_cnt),
    .perf_squash_cnt   (perf_squash_cnt)
  );

  always #5 clock = ~clock;

`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam logic [31:0] KEY = 32'hC0DE_0000;  // memory returns addr ^ KEY

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Memory emulation
  int mem_wait = 0;
  int mem_ctr  = 0;

  // Model: fetch progress described as flags, not as the DUT's states.
  bit          m_started, m_busy, m_dropping, m_parked;
  logic [31:0] m_pc, m_target, m_pk_instr, m_pk_pc4;
  logic [31:0] e_instr, e_pc4, e_fetch, e_squash;
  logic        e_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_started = 0; m_busy = 0; m_dropping = 0; m_parked = 0;
    m_pc = 32'h0; m_target = 32'h0; m_pk_instr = 32'h0; m_pk_pc4 = 32'h0;
    e_instr = 32'h0; e_pc4 = 32'h0; e_valid = 1'b0;
    e_fetch = 32'h0; e_squash = 32'h0;
  endtask

  task automatic model_step(input logic st, input logic be, input logic en,
                            input logic [31:0] ba, input logic ack, input logic [31:0] rd);
    logic        go, redir, loaded;
    logic [31:0] tgt, l_instr, l_pc4;
    go = ~st & en;
    redir = be & go;
    tgt = {ba[31:2], 2'b00};
    loaded = 1'b0; l_instr = 32'h0; l_pc4 = 32'h0;
    if (!m_started) begin
      if (en) begin
        m_started = 1; m_busy = 1;
        if (redir) m_pc = tgt;
      end
    end else if (m_parked) begin
      if (redir) begin
        e_squash++; m_parked = 0; m_busy = 1; m_pc = tgt;
      end else if (go) begin
        loaded = 1; l_instr = m_pk_instr; l_pc4 = m_pk_pc4;
        m_parked = 0; m_busy = 1;
      end
    end else if (m_dropping) begin
      if (ack) begin
        e_squash++; m_dropping = 0;
        m_pc = redir ? tgt : m_target;
      end else if (redir) begin
        m_target = tgt;
      end
    end else begin
      if (ack) begin
        if (redir) begin
          e_squash++; m_pc = tgt;
        end else if (go) begin
          loaded = 1; l_instr = rd; l_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
        end else begin
          m_parked = 1; m_busy = 0; m_pk_instr = rd; m_pk_pc4 = m_pc + 32'd4;
          m_pc = m_pc + 32'd4;
        end
      end else if (redir) begin
        m_dropping = 1; m_target = tgt;
      end
    end
    if (loaded) begin
      e_instr = l_instr; e_pc4 = l_pc4; e_valid = 1'b1; e_fetch++;
    end else if (go) begin
      e_instr = 32'h0; e_pc4 = 32'h0; e_valid = 1'b0;
    end
  endtask

  task automatic mem_drive();
    if (bus.imem_req === 1'b1) begin
      if (mem_ctr >= mem_wait) begin
        bus.imem_ack = 1'b1; bus.imem_rdata = bus.imem_addr ^ KEY; mem_ctr = 0;
      end else begin
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0; mem_ctr++;
      end
    end else begin
      bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0; mem_ctr = 0;
    end
  endtask

  // Called at a negedge: apply inputs, advance the model, wait to next negedge.
  task automatic step(input logic st, input logic be, input logic en, input logic [31:0] ba);
    Stall = st; branchEnable = be; cpu_en = en; branchAddr = ba;
    mem_drive();
    model_step(st, be, en, ba, bus.imem_ack, bus.imem_rdata);
    @(negedge clock);
  endtask

  // Compare every output against the model shortly after each rising edge.
  always @(posedge clock) begin
    #1;
    if (chk_en) begin
      chk("m_valid", {31'h0, if_id_valid}, {31'h0, e_valid});
      chk("m_instr", if_id_instruction, e_instr);
      chk("m_pc4", if_id_pc_4, e_pc4);
      chk("m_req", {31'h0, bus.imem_req}, {31'h0, m_busy});
      chk("m_addr", bus.imem_addr, m_pc);
      chk("m_fcnt", perf_fetch_cnt, PERF ? e_fetch : 32'h0);
      chk("m_scnt", perf_squash_cnt, PERF ? e_squash : 32'h0);
    end
  end

  initial begin
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'h0;
    model_reset();
    repeat (2) @(negedge clock);
    chk("rst_req", {31'h0, bus.imem_req}, 32'h0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
    chk("rst_instr", if_id_instruction, 32'h0);
    chk("rst_pc4", if_id_pc_4, 32'h0);
    chk("rst_fcnt", perf_fetch_cnt, 32'h0);
    chk("rst_scnt", perf_squash_cnt, 32'h0);
    reset = 1'b1;
    chk_en = 1'b1;

    // Start-up and zero-wait streaming
    step(0, 0, 1, 32'h0);
    chk("start_req", {31'h0, bus.imem_req}, 32'h1);
    chk("start_valid", {31'h0, if_id_valid}, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 1, 32'h0);
      chk("stream_pc4", if_id_pc_4, 32'(4 * k));
      chk("stream_valid", {31'h0, if_id_valid}, 32'h1);
    end

    // Taken branch, zero-wait: one bubble
    step(0, 1, 1, 32'h0000_0100);
    chk("br_bubble_valid", {31'h0, if_id_valid}, 32'h0);
    chk("br_bubble_instr", if_id_instruction, 32'h0);
    chk("br_addr", bus.imem_addr, 32'h0000_0100);
    step(0, 0, 1, 32'h0);
    chk("br_pc4", if_id_pc_4, 32'h0000_0104);
    chk("br_instr", if_id_instruction, 32'h0000_0100 ^ KEY);

    // 3-wait memory, redirect during the wait
    step(0, 1, 1, 32'h0000_0010);
    mem_wait = 3;
    step(0, 0, 1, 32'h0);
    chk("w3_addr0", bus.imem_addr, 32'h0000_0010);
    step(0, 1, 1, 32'h0000_0200);
    chk("w3_addr1", bus.imem_addr, 32'h0000_0010);
    chk("w3_req1", {31'h0, bus.imem_req}, 32'h1);
    step(0, 0, 1, 32'h0);
    chk("w3_addr2", bus.imem_addr, 32'h0000_0010);
    step(0, 0, 1, 32'h0);
    chk("w3_newaddr", bus.imem_addr, 32'h0000_0200);
    chk("w3_valid", {31'h0, if_id_valid}, 32'h0);
    repeat (3) step(0, 0, 1, 32'h0);
    chk("w3_still_bubble", {31'h0, if_id_valid}, 32'h0);
    step(0, 0, 1, 32'h0);
    chk("w3_pc4", if_id_pc_4, 32'h0000_0204);
    chk("w3_squash", perf_squash_cnt, PERF ? 32'd3 : 32'd0);
    chk("w3_fetch", perf_fetch_cnt, PERF ? 32'd6 : 32'd0);

    // Stall for 3 cycles with zero-wait memory
    mem_wait = 0;
    step(1, 0, 1, 32'h0);
    chk("st_req", {31'h0, bus.imem_req}, 32'h0);
    chk("st_hold_pc4", if_id_pc_4, 32'h0000_0204);
    step(1, 0, 1, 32'h0);
    step(1, 1, 1, 32'h0000_0300);
    chk("st_hold2_pc4", if_id_pc_4, 32'h0000_0204);
    chk("st_hold2_valid", {31'h0, if_id_valid}, 32'h1);
    step(0, 0, 1, 32'h0);
    chk("st_skid_pc4", if_id_pc_4, 32'h0000_0208);
    chk("st_skid_addr", bus.imem_addr, 32'h0000_0208);
    step(0, 0, 1, 32'h0);
    chk("st_next_pc4", if_id_pc_4, 32'h0000_020C);

    // cpu_en low during a 2-wait request
    mem_wait = 2;
    step(0, 0, 0, 32'h0);
    chk("en_req_held", {31'h0, bus.imem_req}, 32'h1);
    step(0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0);
    chk("en_parked_req", {31'h0, bus.imem_req}, 32'h0);
    chk("en_hold_pc4", if_id_pc_4, 32'h0000_020C);
    step(0, 0, 0, 32'h0);
    step(0, 0, 1, 32'h0);
    chk("en_deliver_pc4", if_id_pc_4, 32'h0000_0210);
    chk("en_deliver_instr", if_id_instruction, 32'h0000_020C ^ KEY);

    // PC wrap at the top of the address space
    mem_wait = 0;
    step(0, 1, 1, 32'hFFFF_FFFF);
    chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 1, 32'h0);
    chk("wrap_pc4", if_id_pc_4, 32'h0000_0000);
    chk("wrap_valid", {31'h0, if_id_valid}, 32'h1);
    chk("wrap_instr", if_id_instruction, 32'h3F21_FFFC);
    chk("wrap_next_addr", bus.imem_addr, 32'h0000_0000);

    // Mixed directed pattern: stalls, branches, enables and wait states
    for (int i = 0; i < 240; i++) begin
      mem_wait = i % 3;
      step((i % 7 == 3) || (i % 7 == 4), (i % 5 == 2), (i % 11 != 6),
           32'h0000_0400 + 32'(i * 12) + 32'(i % 4));
    end

    // Reset in the middle of an outstanding request
    mem_wait = 3;
    step(0, 0, 1, 32'h0);
    step(0, 0, 1, 32'h0);
    chk_en = 1'b0;
    reset = 1'b0;
    #1;
    chk("mrst_req", {31'h0, bus.imem_req}, 32'h0);
    chk("mrst_addr", bus.imem_addr, 32'h0);
    chk("mrst_valid", {31'h0, if_id_valid}, 32'h0);
    chk("mrst_fcnt", perf_fetch_cnt, 32'h0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    chk_en = 1'b1;
    mem_wait = 0;
    step(0, 0, 1, 32'h0);
    step(0, 0, 1, 32'h0);
    chk("mrst_pc4", if_id_pc_4, 32'h0000_0004);
    chk("mrst_fcnt2", perf_fetch_cnt, PERF ? 32'd1 : 32'd0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage pipeline. It owns the PC, issues requests to instruction memory over a req/ack handshake, and drives the IF/ID pipeline register consumed by the decode stage. It also receives the decode stage's control outputs (`Stall`, `branchEnable`, `branchAddr`) and turns them into PC holds, redirects and bubble insertion. A one-entry skid register absorbs a memory response that returns while decode is stalled.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `cpu_en` in 1: global enable; 0 freezes the stage except for completing an outstanding request.
- `Stall` in 1: decode hazard stall; IF/ID must hold.
- `branchEnable` in 1: decode resolved a taken jump/branch/jr.
- `branchAddr` in 32: redirect target; bits [1:0] are ignored and forced to 0.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch word address (byte address, word aligned).
- `imem_ack` in 1: response valid; may arrive in the same cycle as `imem_req`.
- `imem_rdata` in 32: instruction word, valid with `imem_ack`.
- `if_id_instruction` out 32: instruction presented to decode.
- `if_id_pc_4` out 32: PC+4 of that instruction.
- `if_id_valid` out 1: 0 marks a bubble.
- `perf_fetch_cnt` out 32: delivered-instruction count (see Configuration).
- `perf_squash_cnt` out 32: squashed-response count (see Configuration).

## Operation
- Redirect: `redirect = branchEnable & ~Stall & cpu_en`.
- States:
  - IDLE: `imem_req`=0. Entered at reset. Goes to REQ when `cpu_en`=1.
  - REQ: `imem_req`=1, `imem_addr`=pc.
  - HOLD: `imem_req`=0; a word is waiting in the skid register.
  - DRAIN: `imem_req`=1 with the old address; the response will be discarded.
- Handshake rules:
  - Once raised, `imem_req` and `imem_addr` stay stable until the `imem_ack` cycle.
  - Only one request is outstanding at a time.
- REQ, ack received:
  - If `redirect`: discard the word, `pc`<=`branchAddr`, IF/ID<=bubble, stay in REQ.
  - Else if `Stall`=0 and `cpu_en`=1: IF/ID<={`imem_rdata`, pc+4, 1}, `pc`<=pc+4, stay in REQ.
  - Else: skid<={`imem_rdata`, pc+4}, `pc`<=pc+4, go to HOLD.
- REQ, no ack:
  - If `redirect`: latch `pend_addr`<=`branchAddr`, IF/ID<=bubble, go to DRAIN.
  - `cpu_en`=0 does not drop `imem_req`.
- DRAIN, on ack: discard the word, `pc`<=`pend_addr`, go to REQ. A further redirect while in DRAIN overwrites `pend_addr`.
- HOLD:
  - `redirect`: drop the skid, `pc`<=`branchAddr`, IF/ID<=bubble, go to REQ.
  - `Stall`=0 and `cpu_en`=1: IF/ID<=skid with valid=1, go to REQ.
- `Stall`=1 with no redirect: IF/ID holds its value.
- Any cycle where IF/ID is not loaded, stalled or redirected while `Stall`=0 and `cpu_en`=1: IF/ID<=bubble, so decode never re-executes an instruction.
- Bubble encoding: instruction 32'h0 (sll $0 NOP), pc_4 0, valid 0.
- Arithmetic: pc+4 is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0). There are no delay slots.

## Timing
- Reset (asynchronous assert): state=IDLE, pc=`RESET_PC`, `imem_req`=0, `imem_addr`=`RESET_PC`, IF/ID=bubble, skid cleared, `pend_addr`=0, counters=0.
- Reset deassert, then the first edge with `cpu_en`=1: go to REQ; `imem_req` is high in the next cycle.
- Zero-wait memory (ack in the request cycle): one instruction per clock; the word appears on `if_id_*` one edge after the ack cycle.
- Taken branch with zero-wait memory costs exactly 1 bubble.
- N-wait memory with a redirect during the wait: one bubble, plus the remaining wait cycles, plus one cycle for the new fetch.
- Reset asserted mid-request: the request is abandoned. Memory must tolerate `imem_req` dropping.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `perf_fetch_cnt` increments on every IF/ID load with valid=1.
  - `perf_squash_cnt` increments on every discarded ack word and every dropped skid.
  - Both counters wrap at 2^32 and clear on reset.
- Not defined: both outputs are tied to 32'h0 and no counter flops are synthesized.

## Test plan
- Reset, `RESET_PC`=0x0, zero-wait memory returning addr-as-data for 4 cycles -> `if_id_pc_4` = 4, 8, 12, 16 on consecutive cycles, valid=1.
- Zero-wait memory; `branchEnable`=1 with `branchAddr`=0x100 while IF/ID holds pc_4=0x8 -> next cycle bubble (valid=0, instruction 0); the cycle after, `if_id_pc_4`=0x104.
- 3-wait memory; redirect to 0x200 one cycle after the request for 0x10 -> `imem_addr` stays 0x10 until ack; that word is never delivered; next request is 0x200; `perf_squash_cnt`=1.
- `Stall`=1 for 3 cycles with zero-wait memory -> IF/ID holds; exactly one new request completes into the skid; after `Stall` falls, the skid word arrives next cycle with no duplicate or lost PC.
- `cpu_en`=0 during an outstanding 2-wait request -> `imem_req` held until ack, word parked in HOLD; on `cpu_en`=1 with `Stall`=0 the word is delivered.
- PC=32'hFFFF_FFFC fetch -> `if_id_pc_4`=0; next `imem_addr`=0.
